// File: rtl/aes_block_packer.sv
// Packs a 32-bit word stream into 128-bit AES blocks; the first word of each packet is
// the command word. Blocks leave over a valid/ready channel, and in_busy backpressures the stream.
module aes_block_packer #(
   parameter int unsigned WORD_WIDTH  = 32,
   parameter int unsigned BLOCK_WIDTH = 128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_wren,
   input  logic [WORD_WIDTH-1:0]  in_data,
   input  logic                   in_tlast,
   output logic                   in_busy,
   output logic                   blk_valid,
   input  logic                   blk_ready,
   output logic [BLOCK_WIDTH-1:0] blk_data,
   output logic                   blk_cmd,
   output logic                   blk_last,
   output logic                   err_partial
);

   localparam int unsigned WORDS = BLOCK_WIDTH / WORD_WIDTH;

   typedef enum logic {S_CMD, S_DATA} state_t;

   state_t                 state, state_nxt;
   logic [1:0]             cnt, cnt_nxt;
   logic [BLOCK_WIDTH-1:0] asm_data, asm_data_nxt;
   logic                   asm_cmd, asm_cmd_nxt;
   logic                   asm_last, asm_last_nxt;
   logic                   asm_full, asm_full_nxt;
   logic                   err_nxt;
   logic                   accept;
   logic                   xfer;

   // Stall only when both registers are occupied and the output is not draining.
   assign in_busy = asm_full && blk_valid && !blk_ready;
   assign accept  = in_wren && !in_busy;
   assign xfer    = asm_full && (!blk_valid || blk_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_CMD;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and assembly register; a transferring asm is cleared before the new word lands.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      asm_data_nxt = asm_data;
      asm_cmd_nxt  = asm_cmd;
      asm_last_nxt = asm_last;
      asm_full_nxt = asm_full;
      err_nxt      = err_partial;

      if (xfer) begin
         asm_data_nxt = '0;
         asm_cmd_nxt  = 1'b0;
         asm_last_nxt = 1'b0;
         asm_full_nxt = 1'b0;
      end

      if (accept) begin
         unique case (state)
            S_CMD: begin
               asm_data_nxt = {in_data, {(BLOCK_WIDTH-WORD_WIDTH){1'b0}}};
               asm_cmd_nxt  = 1'b1;
               asm_last_nxt = in_tlast;
               asm_full_nxt = 1'b1;
               cnt_nxt      = 2'd0;
               state_nxt    = in_tlast ? S_CMD : S_DATA;
            end
            S_DATA: begin
               for (int unsigned i = 0; i < WORDS; i++) begin
                  if (cnt == 2'(i)) begin
                     asm_data_nxt[BLOCK_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH] = in_data;
                  end
               end
               asm_cmd_nxt  = 1'b0;
               asm_last_nxt = in_tlast;
               asm_full_nxt = (cnt == 2'd3) || in_tlast;
               if (in_tlast) begin
                  state_nxt = S_CMD;
                  cnt_nxt   = 2'd0;
                  // Unwritten words are already zero because asm is cleared on every transfer.
                  if (cnt != 2'd3) begin
                     err_nxt = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + 2'd1;
               end
            end
            default: begin
               state_nxt = S_CMD;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= 2'd0;
         asm_data    <= '0;
         asm_cmd     <= 1'b0;
         asm_last    <= 1'b0;
         asm_full    <= 1'b0;
         err_partial <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         asm_data    <= asm_data_nxt;
         asm_cmd     <= asm_cmd_nxt;
         asm_last    <= asm_last_nxt;
         asm_full    <= asm_full_nxt;
         err_partial <= err_nxt;
      end
   end

   // Output register holds its payload until accepted; reload and accept may share an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blk_valid <= 1'b0;
         blk_data  <= '0;
         blk_cmd   <= 1'b0;
         blk_last  <= 1'b0;
      end else if (xfer) begin
         blk_valid <= 1'b1;
         blk_data  <= asm_data;
         blk_cmd   <= asm_cmd;
         blk_last  <= asm_last;
      end else if (blk_ready) begin
         blk_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: expected blocks are queued as words are driven
// and popped when the DUT hands a block over.
module tb_aes_block_packer;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_wren;
   logic [31:0]  in_data;
   logic         in_tlast;
   logic         in_busy;
   logic         blk_valid;
   logic         blk_ready;
   logic [127:0] blk_data;
   logic         blk_cmd;
   logic         blk_last;
   logic         err_partial;

   typedef struct {
      logic [127:0] data;
      logic         cmd;
      logic         last;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   aes_block_packer #(.WORD_WIDTH(32), .BLOCK_WIDTH(128)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_wren     (in_wren),
      .in_data     (in_data),
      .in_tlast    (in_tlast),
      .in_busy     (in_busy),
      .blk_valid   (blk_valid),
      .blk_ready   (blk_ready),
      .blk_data    (blk_data),
      .blk_cmd     (blk_cmd),
      .blk_last    (blk_last),
      .err_partial (err_partial)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic [127:0] d, input logic c, input logic l);
      exp_t e;
      e.data = d;
      e.cmd  = c;
      e.last = l;
      exp_q.push_back(e);
   endtask

   // Pops the expected block whenever a handshake will complete on the next edge.
   task automatic monitor();
      exp_t e;
      logic bad;
      forever begin
         @(negedge clk);
         if (!reset && blk_valid && blk_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_block: got data=%h cmd=%b last=%b, required no block",
                        blk_data, blk_cmd, blk_last);
            end else begin
               e = exp_q.pop_front();
               if ({blk_data, blk_cmd, blk_last} !== {e.data, e.cmd, e.last}) begin
                  fails++;
                  $display("FAIL block: got data=%h cmd=%b last=%b, required data=%h cmd=%b last=%b",
                           blk_data, blk_cmd, blk_last, e.data, e.cmd, e.last);
               end
            end
            bad = 1'b0;
            for (int i = 0; i < 4; i++) begin
               if (blk_data[i*32 +: 32] === 32'hDEADBEEF) bad = 1'b1;
            end
            tests++;
            if (bad !== 1'b0) begin
               fails++;
               $display("FAIL ignored_word_leaked: got data=%h, required no DEADBEEF word", blk_data);
            end
         end
      end
   endtask

   // Drives one word for one cycle; called just after a rising edge.
   task automatic send(input logic [31:0] w, input logic last, output logic acc);
      in_wren  = 1'b1;
      in_data  = w;
      in_tlast = last;
      @(negedge clk);
      acc = !in_busy;
      @(posedge clk);
      #1;
      in_wren  = 1'b0;
      in_tlast = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: got %0d blocks outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      tests++;
      if (blk_valid !== 1'b0) begin
         fails++;
         $display("FAIL %s_valid_drop: got blk_valid=%b, required 0", name, blk_valid);
      end
   endtask

   task automatic check_idle(input string name);
      tests++;
      if ({blk_valid, blk_data, blk_cmd, blk_last, err_partial, in_busy} !== 133'b0) begin
         fails++;
         $display("FAIL %s: got valid=%b data=%h cmd=%b last=%b err=%b busy=%b, required all 0",
                  name, blk_valid, blk_data, blk_cmd, blk_last, err_partial, in_busy);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_wren   = 1'b0;
      in_data   = '0;
      in_tlast  = 1'b0;
      blk_ready = 1'b0;
      #1;
      check_idle("reset_during");
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_idle("reset_after");
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      logic acc;
      logic busy_seen = 1'b0;
      blk_ready = 1'b1;
      push_exp({32'h11, 96'b0}, 1'b1, 1'b0);
      push_exp({32'h1, 32'h2, 32'h3, 32'h4}, 1'b0, 1'b1);
      send(32'h11, 1'b0, acc);
      busy_seen |= !acc;
      tests++;
      if (blk_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_latency_cmd: got blk_valid=%b one edge after cmd, required 0", blk_valid);
      end
      send(32'h1, 1'b0, acc);
      busy_seen |= !acc;
      tests++;
      if ({blk_valid, blk_cmd} !== 2'b11) begin
         fails++;
         $display("FAIL basic_cmd_out: got valid=%b cmd=%b, required 1 1", blk_valid, blk_cmd);
      end
      send(32'h2, 1'b0, acc);
      busy_seen |= !acc;
      send(32'h3, 1'b0, acc);
      busy_seen |= !acc;
      send(32'h4, 1'b1, acc);
      busy_seen |= !acc;
      tests++;
      if (blk_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_latency_data: got blk_valid=%b at completing edge, required 0", blk_valid);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({blk_valid, blk_last} !== 2'b11) begin
         fails++;
         $display("FAIL basic_data_out: got valid=%b last=%b, required 1 1", blk_valid, blk_last);
      end
      tests++;
      if (busy_seen !== 1'b0) begin
         fails++;
         $display("FAIL basic_busy: got in_busy seen=%b, required 0", busy_seen);
      end
      wait_drain("basic");
   endtask

   task automatic test_back_to_back();
      logic        acc;
      logic [31:0] words [9];
      logic [8:0]  exp_acc = 9'b000011111;
      int          dropped[$];
      blk_ready = 1'b0;
      words[0] = 32'h22;
      for (int i = 1; i < 9; i++) words[i] = 32'(i);
      push_exp({32'h22, 96'b0}, 1'b1, 1'b0);
      push_exp({32'h1, 32'h2, 32'h3, 32'h4}, 1'b0, 1'b0);
      push_exp({32'h5, 32'h6, 32'h7, 32'h8}, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         send(words[i], i == 8, acc);
         tests++;
         if (acc !== exp_acc[i]) begin
            fails++;
            $display("FAIL b2b_accept[%0d]: got accepted=%b, required %b", i, acc, exp_acc[i]);
         end
         if (!acc) dropped.push_back(i);
      end
      tests++;
      if ({in_busy, blk_valid, blk_data} !== {1'b1, 1'b1, 32'h22, 96'b0}) begin
         fails++;
         $display("FAIL b2b_stall: got busy=%b valid=%b data=%h, required busy=1 valid=1 cmd block",
                  in_busy, blk_valid, blk_data);
      end
      blk_ready = 1'b1;
      foreach (dropped[k]) begin
         send(words[dropped[k]], dropped[k] == 8, acc);
         tests++;
         if (acc !== 1'b1) begin
            fails++;
            $display("FAIL b2b_resend[%0d]: got accepted=%b, required 1", dropped[k], acc);
         end
      end
      wait_drain("b2b");
   endtask

   task automatic test_partial();
      logic acc;
      blk_ready = 1'b1;
      tests++;
      if (err_partial !== 1'b0) begin
         fails++;
         $display("FAIL partial_pre: got err_partial=%b, required 0", err_partial);
      end
      push_exp({32'h33, 96'b0}, 1'b1, 1'b0);
      push_exp({32'h5, 32'h6, 64'b0}, 1'b0, 1'b1);
      send(32'h33, 1'b0, acc);
      send(32'h5, 1'b0, acc);
      send(32'h6, 1'b1, acc);
      wait_drain("partial");
      tests++;
      if (err_partial !== 1'b1) begin
         fails++;
         $display("FAIL partial_flag: got err_partial=%b, required 1", err_partial);
      end
      push_exp({32'h44, 96'b0}, 1'b1, 1'b0);
      push_exp({32'h9, 32'hA, 32'hB, 32'hC}, 1'b0, 1'b1);
      send(32'h44, 1'b0, acc);
      send(32'h9, 1'b0, acc);
      send(32'hA, 1'b0, acc);
      send(32'hB, 1'b0, acc);
      send(32'hC, 1'b1, acc);
      wait_drain("clean");
      tests++;
      if (err_partial !== 1'b1) begin
         fails++;
         $display("FAIL partial_sticky: got err_partial=%b, required 1", err_partial);
      end
   endtask

   task automatic test_cmd_only();
      logic acc;
      blk_ready = 1'b1;
      push_exp({32'h55, 96'b0}, 1'b1, 1'b1);
      push_exp({32'h66, 96'b0}, 1'b1, 1'b1);
      send(32'h55, 1'b1, acc);
      send(32'h66, 1'b1, acc);
      wait_drain("cmd_only");
   endtask

   task automatic test_reset_mid();
      logic acc;
      blk_ready = 1'b0;
      send(32'h77, 1'b0, acc);
      send(32'h1, 1'b0, acc);
      send(32'h2, 1'b0, acc);
      tests++;
      if (blk_valid !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_pre: got blk_valid=%b, required 1", blk_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      check_idle("reset_mid_async");
      @(posedge clk);
      #1;
      reset = 1'b0;
      blk_ready = 1'b1;
      push_exp({32'hA, 96'b0}, 1'b1, 1'b0);
      push_exp({32'h10, 32'h11, 32'h12, 32'h13}, 1'b0, 1'b1);
      send(32'hA, 1'b0, acc);
      send(32'h10, 1'b0, acc);
      send(32'h11, 1'b0, acc);
      send(32'h12, 1'b0, acc);
      send(32'h13, 1'b1, acc);
      wait_drain("reset_mid");
   endtask

   task automatic test_busy_ignore();
      logic acc;
      blk_ready = 1'b0;
      push_exp({32'h88, 96'b0}, 1'b1, 1'b0);
      push_exp({32'h1, 32'h2, 32'h3, 32'h4}, 1'b0, 1'b0);
      push_exp({32'h5, 32'h6, 32'h7, 32'h8}, 1'b0, 1'b1);
      send(32'h88, 1'b0, acc);
      for (int i = 1; i <= 4; i++) send(32'(i), 1'b0, acc);
      send(32'hDEADBEEF, 1'b1, acc);
      tests++;
      if (acc !== 1'b0) begin
         fails++;
         $display("FAIL ignore_accept: got accepted=%b for busy write, required 0", acc);
      end
      blk_ready = 1'b1;
      for (int i = 5; i <= 8; i++) send(32'(i), i == 8, acc);
      wait_drain("ignore");
      tests++;
      if (err_partial !== 1'b0) begin
         fails++;
         $display("FAIL ignore_err: got err_partial=%b, required 0", err_partial);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_back_to_back();
      test_partial();
      test_cmd_only();
      test_reset_mid();
      test_busy_ignore();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/aes_block_packer.md
# aes_block_packer

Sits between the AXI-Stream slave front end and the AES controller on the `s00_axis_aclk` domain. Packs the 32-bit word stream (write-enable, data, tlast) into 128-bit AES blocks. The first word of every packet is the command word. Assembled blocks are handed to the controller over a valid/ready channel, and the block drives the slave's busy input to backpressure the stream.

## Interface
Parameters:
- `WORD_WIDTH`, 32, input word width. Only 32 is supported.
- `BLOCK_WIDTH`, 128, output block width. Must equal 4 × `WORD_WIDTH`.

Ports (clock and reset first):
- `clk`  in  1  Block clock.
- `reset`  in  1  Reset. One clock; reset is asynchronous and active-high.
- `in_wren`  in  1  Word strobe from the stream slave.
- `in_data`  in  32  Word from the stream slave.
- `in_tlast`  in  1  Marks the last word of a packet; qualified by `in_wren`.
- `in_busy`  out  1  High when a word cannot be accepted this cycle.
- `blk_valid`  out  1  Output block is valid.
- `blk_ready`  in  1  Controller accepts the block.
- `blk_data`  out  128  Assembled block.
- `blk_cmd`  out  1  Block carries the command word.
- `blk_last`  out  1  Final block of the packet.
- `err_partial`  out  1  Sticky flag: a packet ended mid-block.

## Operation
- Word acceptance:
  - A word is accepted when `in_wren && !in_busy`.
  - `in_wren` while `in_busy` is high is ignored. No state changes.
- Datapath: one assembly register (asm) and one output register (out).
- State machine:
  - S_CMD, the reset state: the next accepted word is a command.
    - asm ← {word, 96'b0}; asm_cmd ← 1; asm_last ← in_tlast; asm marked full.
    - Go to S_DATA, or stay in S_CMD if in_tlast.
  - S_DATA: accepted words fill asm in big-endian word order.
    - Word index 0 goes to [127:96], index 3 to [31:0].
    - 2-bit counter `cnt` holds the word index and increments per accepted word, wrapping 3→0.
    - asm is marked full when the word at cnt==3 is accepted, or when in_tlast is seen.
  - On in_tlast: asm_last ← 1, go to S_CMD, cnt ← 0.
- Partial block: in_tlast with cnt≠3 zero-fills the unwritten words and sets `err_partial`. The flag stays set until reset.
- Transfer asm→out happens when asm is full and out is free (`!blk_valid || blk_ready`).
  - out takes data, cmd and last; asm is cleared.
  - A word accepted in the same cycle lands in the freshly cleared asm.
- `in_busy` = asm_full && blk_valid && !blk_ready. It is combinational from registered state and `blk_ready`.
- Block ordering is preserved. No word is dropped or duplicated.

## Timing
- Reset values: `blk_valid`=0, `blk_data`=0, `blk_cmd`=0, `blk_last`=0, `err_partial`=0.
  - Internally: state=S_CMD, cnt=0, asm empty.
  - `in_busy`=0 during and after reset.
- Latency: the word completing a block is accepted at edge E; `blk_valid` is high after edge E+1 if out is free.
- Throughput: one word per cycle sustained while `blk_ready`=1. No bubbles.
- Handshake:
  - `blk_data`, `blk_cmd` and `blk_last` are stable while `blk_valid && !blk_ready`.
  - `blk_valid` drops the edge after acceptance unless a new block transfers on that same edge.
- Simultaneous events:
  - Output accept and asm→out transfer on one edge is allowed.
  - A word accept on that same edge is also allowed.
- Reset asserted mid-packet: everything clears immediately. The first word accepted after release is treated as a command.

## Test plan
- Cmd 0x00000011 plus words 1,2,3,4, tlast on word 4, `blk_ready`=1 → two blocks:
  - {0x00000011, 96'b0} with cmd=1, last=0.
  - 0x00000001_00000002_00000003_00000004 with cmd=0, last=1.
  - `in_busy` never high.
- `blk_ready`=0, cmd plus 8 words written back-to-back:
  - `in_busy` rises once out holds the cmd block and asm holds data block 1; stays high.
  - Later writes are ignored. Release `blk_ready` and resend the dropped words.
  - Result: three blocks in order, last=1 on the third, no duplicates.
- Cmd plus words 5,6, tlast on 6 → data block 0x00000005_00000006_00000000_00000000, last=1. `err_partial`=1, still 1 after the next clean packet.
- Cmd-only packet with tlast on the cmd word → single block with cmd=1, last=1. The next word is treated as a command.
- Assert `reset` after 2 data words of a block → all outputs go to 0 asynchronously. Next packet cmd 0xA plus 4 words → correct blocks, no stale data.
- `in_wren` with `in_busy`=1, data 0xDEADBEEF → ignored; never appears in any `blk_data`.
